// File: rtl/mult_result_fifo.sv
// mult_result_fifo: captures multiplier/popcount results into a small FIFO that
// software drains over the saddress/srd/swr register bus.
//
// Ports:
//   clk, n_reset          clock, asynchronous active-low reset
//   res_done              one-cycle strobe; res_w/res_ones/res_ovf valid
//   res_w, res_ones,      result word, ones count, overflow flag
//   res_ovf
//   saddress, srd, swr,   register bus (strobes are one cycle, synchronous)
//   sdata_in, sdata_out   write data in, registered read data out
//   irq                   level interrupt, high while threshold event is pending
//   level                 current entry count, 0..DEPTH
//
// Optional build macro RESFIFO_TIMESTAMP_EN: adds a free-running 16-bit cycle
// counter whose value is stored with each entry and read back at BASE+0x20.
module mult_result_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned AW     = 3,
    parameter int unsigned THRESH = 6,
    parameter logic [15:0] BASE   = 16'h03B0
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          res_done,
    input  logic [31:0]   res_w,
    input  logic [5:0]    res_ones,
    input  logic          res_ovf,
    input  logic [15:0]   saddress,
    input  logic          srd,
    input  logic          swr,
    input  logic [31:0]   sdata_in,
    output logic [31:0]   sdata_out,
    output logic          irq,
    output logic [AW:0]   level
);

    localparam logic [15:0] ADDR_HEAD_W    = BASE;
    localparam logic [15:0] ADDR_HEAD_META = BASE + 16'h0008;
    localparam logic [15:0] ADDR_POP       = BASE + 16'h0010;
    localparam logic [15:0] ADDR_STAT      = BASE + 16'h0018;
`ifdef RESFIFO_TIMESTAMP_EN
    localparam logic [15:0] ADDR_TS        = BASE + 16'h0020;
`endif
    localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [AW:0] THRESH_L = (AW+1)'(THRESH);

    typedef enum logic [1:0] {IrqIdle, IrqPend, IrqAcked} irq_state_e;

    logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]  level_d;
    logic [38:0]  mem [DEPTH];
    logic [38:0]  head;
    logic [15:0]  drop_cnt_q;
    logic         uflow_q;
    logic [31:0]  sdata_q, rd_data;
    irq_state_e   irq_state_q, irq_state_d;

    logic empty, full, pop_req, ctrl_wr, flush, clr, ack;
    logic do_pop, do_push, wr_en, drop;

    // Only the low CTRL bits carry meaning; POP ignores its data entirely.
    logic unused_sdata;
    assign unused_sdata = ^sdata_in[31:3];

    assign level   = wr_ptr_q - rd_ptr_q;
    assign empty   = (level == '0);
    assign full    = (level == DEPTH_L);
    assign pop_req = swr && (saddress == ADDR_POP);
    assign ctrl_wr = swr && (saddress == ADDR_STAT);
    assign flush   = ctrl_wr && sdata_in[0];
    assign clr     = ctrl_wr && sdata_in[1];
    assign ack     = ctrl_wr && sdata_in[2];

    // A pop frees the slot for a same-cycle push when full, so no drop then.
    assign do_pop  = pop_req && !empty;
    assign do_push = res_done && (!full || do_pop);
    assign wr_en   = do_push && !flush;
    assign drop    = res_done && full && !do_pop && !flush;

    assign wr_ptr_d = flush ? '0 : wr_ptr_q + (AW+1)'(wr_en);
    assign rd_ptr_d = flush ? '0 : rd_ptr_q + (AW+1)'(do_pop);
    assign level_d  = wr_ptr_d - rd_ptr_d;

    assign head = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= {res_ovf, res_ones, res_w};
        end
    end

`ifdef RESFIFO_TIMESTAMP_EN
    logic [15:0] ts_q;
    logic [15:0] ts_mem [DEPTH];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) ts_q <= '0;
        else          ts_q <= ts_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ts_mem[wr_ptr_q[AW-1:0]] <= ts_q;
        end
    end
`endif

    // Read data reflects state before any same-cycle push or pop.
    always_comb begin
        rd_data = '0;
        case (saddress)
            ADDR_HEAD_W:    if (!empty) rd_data = head[31:0];
            ADDR_HEAD_META: if (!empty) rd_data = {25'b0, head[38:32]};
            ADDR_STAT:      rd_data = {drop_cnt_q, 8'(level), 4'b0, irq, uflow_q, full, empty};
`ifdef RESFIFO_TIMESTAMP_EN
            ADDR_TS:        if (!empty) rd_data = {16'b0, ts_mem[rd_ptr_q[AW-1:0]]};
`endif
            default:        ;
        endcase
    end

    always_comb begin
        irq_state_d = irq_state_q;
        if (flush) begin
            irq_state_d = IrqIdle;
        end else begin
            unique case (irq_state_q)
                IrqIdle:  if (level_d >= THRESH_L) irq_state_d = IrqPend;
                IrqPend:  if (ack) irq_state_d = IrqAcked;
                IrqAcked: if (level_d < THRESH_L) irq_state_d = IrqIdle;
                default:  irq_state_d = IrqIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            drop_cnt_q  <= '0;
            uflow_q     <= 1'b0;
            sdata_q     <= '0;
            irq_state_q <= IrqIdle;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            irq_state_q <= irq_state_d;
            if (srd) sdata_q <= rd_data;
            if (clr) begin
                drop_cnt_q <= '0;
                uflow_q    <= 1'b0;
            end else begin
                if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
                if (pop_req && empty) uflow_q <= 1'b1;
            end
        end
    end

    assign sdata_out = sdata_q;
    assign irq       = (irq_state_q == IrqPend);

endmodule

// File: tb/tb_mult_result_fifo.sv
module tb_mult_result_fifo;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned AW     = 3;
    localparam int unsigned THRESH = 6;
    localparam logic [15:0] BASE   = 16'h03B0;
    localparam logic [15:0] A_W    = BASE;
    localparam logic [15:0] A_META = BASE + 16'h0008;
    localparam logic [15:0] A_POP  = BASE + 16'h0010;
    localparam logic [15:0] A_STAT = BASE + 16'h0018;
    localparam logic [15:0] A_TS   = BASE + 16'h0020;
    localparam logic [15:0] A_BAD  = BASE + 16'h0028;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        res_done = 1'b0;
    logic [31:0] res_w = '0;
    logic [5:0]  res_ones = '0;
    logic        res_ovf = 1'b0;
    logic [15:0] saddress = '0;
    logic        srd = 1'b0;
    logic        swr = 1'b0;
    logic [31:0] sdata_in = '0;
    logic [31:0] sdata_out;
    logic        irq;
    logic [AW:0] level;

    mult_result_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .THRESH(THRESH),
        .BASE  (BASE)
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .res_done (res_done),
        .res_w    (res_w),
        .res_ones (res_ones),
        .res_ovf  (res_ovf),
        .saddress (saddress),
        .srd      (srd),
        .swr      (swr),
        .sdata_in (sdata_in),
        .sdata_out(sdata_out),
        .irq      (irq),
        .level    (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic [5:0]  ones;
        logic        ovf;
    } ent_t;

    // Reference model: a plain queue plus counters and interrupt flags.
    ent_t        q[$];
    int unsigned m_drops;
    logic        m_uf, m_pend, m_acked;
    logic [31:0] m_sdata;
    int          total = 0;
    int          bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [15:0] a);
        int n = q.size();
        if (a == A_W)    return (n == 0) ? 32'h0 : q[0].w;
        if (a == A_META) return (n == 0) ? 32'h0 : {25'b0, q[0].ovf, q[0].ones};
        if (a == A_STAT) return {m_drops[15:0], 8'(n), 4'b0, m_pend, m_uf,
                                 (n == DEPTH), (n == 0)};
        return 32'h0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_drops = 0;
        m_uf    = 1'b0;
        m_pend  = 1'b0;
        m_acked = 1'b0;
        m_sdata = '0;
    endtask

    task automatic model_update(input logic push, input ent_t e, input logic wr,
                                input logic [15:0] addr, input logic [31:0] data);
        logic pop_req, ctrl, flush;
        int   n;
        pop_req = wr && (addr == A_POP);
        ctrl    = wr && (addr == A_STAT);
        flush   = ctrl && data[0];
        if (pop_req && q.size() == 0) m_uf = 1'b1;
        if (flush) begin
            q.delete();
        end else begin
            if (pop_req && q.size() > 0) void'(q.pop_front());
            if (push) begin
                if (q.size() < DEPTH) q.push_back(e);
                else if (m_drops < 32'hFFFF) m_drops++;
            end
        end
        if (ctrl && data[1]) begin
            m_drops = 0;
            m_uf    = 1'b0;
        end
        n = q.size();
        if (flush) begin
            m_pend  = 1'b0;
            m_acked = 1'b0;
        end else if (!m_pend && !m_acked && n >= THRESH) begin
            m_pend = 1'b1;
        end else if (m_pend && ctrl && data[2]) begin
            m_pend  = 1'b0;
            m_acked = 1'b1;
        end else if (m_acked && n < THRESH) begin
            m_acked = 1'b0;
        end
    endtask

    // One bus/result cycle; inputs driven away from the edge, outputs checked #1 after it.
    task automatic cycle(input logic push, input logic [31:0] w, input logic [5:0] ones,
                         input logic ovf, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [31:0] data);
        ent_t e;
        e.w = w; e.ones = ones; e.ovf = ovf;
        res_done = push; res_w = w; res_ones = ones; res_ovf = ovf;
        srd = rd; swr = wr; saddress = addr; sdata_in = data;
        if (rd) m_sdata = model_rd(addr);
        @(posedge clk);
        #1;
        model_update(push, e, wr, addr, data);
        res_done = 1'b0; srd = 1'b0; swr = 1'b0;
        check_eq("sdata_out", sdata_out, m_sdata);
        check_eq("level", 32'(level), 32'(q.size()));
        check_eq("irq", {31'b0, irq}, {31'b0, m_pend});
    endtask

    task automatic push_r(input logic [31:0] w, input logic [5:0] ones, input logic ovf);
        cycle(1'b1, w, ones, ovf, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic rd_reg(input logic [15:0] a);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, a, '0);
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [31:0] d);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, a, d);
    endtask

    logic [15:0] addrs [6];
    logic [15:0] a;
    logic [31:0] d;
    logic [31:0] drops_before;

    initial begin
        addrs[0] = A_W; addrs[1] = A_META; addrs[2] = A_POP;
        addrs[3] = A_STAT; addrs[4] = A_TS; addrs[5] = A_BAD;
        model_reset();
        #12;
        check_eq("rst_sdata", sdata_out, 32'h0);
        check_eq("rst_level", 32'(level), 32'h0);
        @(negedge clk);
        n_reset = 1'b1;

        // 1: reset status
        rd_reg(A_STAT);
        check_eq("t1_status", sdata_out, 32'h0000_0001);

        // 2: single entry peek and pop
        push_r(32'h0000_0C00, 6'd2, 1'b0);
        rd_reg(A_W);
        check_eq("t2_head_w", sdata_out, 32'h0000_0C00);
        rd_reg(A_META);
        check_eq("t2_head_meta", sdata_out, 32'h0000_0002);
        wr_reg(A_POP, 32'h1);
        rd_reg(A_STAT);
        check_eq("t2_empty", {31'b0, sdata_out[0]}, 32'h1);

        // 3: overfill, drops, FIFO order
        for (int i = 1; i <= 10; i++) push_r(32'(i), 6'(i), 1'b0);
        rd_reg(A_STAT);
        check_eq("t3_status", sdata_out, 32'h0002_080A);
        for (int i = 1; i <= 8; i++) begin
            rd_reg(A_W);
            check_eq("t3_order", sdata_out, 32'(i));
            wr_reg(A_POP, 32'h0);
        end
        wr_reg(A_STAT, 32'h6);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);

        // 4: threshold interrupt and acknowledge
        for (int i = 0; i < 6; i++) push_r(32'h100 + 32'(i), 6'd1, 1'b1);
        check_eq("t4_irq_set", {31'b0, irq}, 32'h1);
        wr_reg(A_STAT, 32'h4);
        check_eq("t4_irq_ack", {31'b0, irq}, 32'h0);
        wr_reg(A_POP, 32'h0);
        check_eq("t4_level5", 32'(level), 32'd5);
        push_r(32'h200, 6'd1, 1'b0);
        check_eq("t4_irq_again", {31'b0, irq}, 32'h1);
        for (int i = 0; i < 6; i++) wr_reg(A_POP, 32'h0);
        wr_reg(A_STAT, 32'h4);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);

        // 5: simultaneous push/pop, underflow, clear
        for (int i = 0; i < 3; i++) push_r(32'h300 + 32'(i), 6'd3, 1'b0);
        cycle(1'b1, 32'h3FF, 6'd9, 1'b0, 1'b0, 1'b1, A_POP, '0);
        check_eq("t5_level3", 32'(level), 32'd3);
        for (int i = 0; i < 3; i++) wr_reg(A_POP, 32'h0);
        wr_reg(A_POP, 32'h0);
        rd_reg(A_STAT);
        check_eq("t5_uflow", {31'b0, sdata_out[2]}, 32'h1);
        wr_reg(A_STAT, 32'h2);
        rd_reg(A_STAT);
        check_eq("t5_cleared", sdata_out, 32'h0000_0001);

        // 6: flush with concurrent push
        for (int i = 0; i < 5; i++) push_r(32'h400 + 32'(i), 6'd4, 1'b0);
        rd_reg(A_STAT);
        drops_before = {16'b0, sdata_out[31:16]};
        cycle(1'b1, 32'h4FF, 6'd5, 1'b0, 1'b0, 1'b1, A_STAT, 32'h1);
        check_eq("t6_flush_level", 32'(level), 32'h0);
        check_eq("t6_flush_irq", {31'b0, irq}, 32'h0);
        rd_reg(A_STAT);
        check_eq("t6_drops", {16'b0, sdata_out[31:16]}, drops_before);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            a = addrs[$urandom_range(0, 5)];
            d = $urandom;
            if (a == A_STAT && d[0] && ($urandom_range(0, 3) != 0)) d[0] = 1'b0;
            cycle($urandom_range(0, 99) < 55, $urandom, 6'($urandom_range(0, 32)),
                  1'($urandom), 1'($urandom), $urandom_range(0, 99) < 30, a, d);
        end

        // Fill, make sdata/irq nonzero, then reset asynchronously mid-push
        for (int i = 0; i < 7; i++) push_r(32'h500 + 32'(i), 6'd1, 1'b0);
        rd_reg(A_W);
        @(posedge clk);
        #2;
        res_done = 1'b1;
        res_w = 32'hDEAD_BEEF;
        #2;
        n_reset = 1'b0;
        #1;
        check_eq("rst_mid_sdata", sdata_out, 32'h0);
        check_eq("rst_mid_irq", {31'b0, irq}, 32'h0);
        check_eq("rst_mid_level", 32'(level), 32'h0);
        @(negedge clk);
        res_done = 1'b0;
        n_reset = 1'b1;
        model_reset();
        rd_reg(A_STAT);
        check_eq("rst_mid_status", sdata_out, 32'h0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_result_fifo.md
Name: mult_result_fifo

Overview:
Downstream consumer of the 24x24 multiplier/popcount peripheral. Captures every completed result (32-bit product W, ones count, overflow flag) on a one-cycle done pulse into a small FIFO. Software can then drain results at its own pace over the same saddress/srd/swr register bus, so back-to-back operations are no longer lost. Provides a level-threshold interrupt with acknowledge.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..64
AW, 3, log2(DEPTH); pointer width
THRESH, 6, irq fires when level >= THRESH; 1..DEPTH
BASE, 16'h03B0, register base address

Ports:
clk  input  1  system clock, all logic on rising edge
n_reset  input  1  reset, asynchronous, active-low
res_done  input  1  one-cycle strobe: result inputs valid this cycle
res_w  input  32  product low word W
res_ones  input  6  ones count of W, 0..32
res_ovf  input  1  1 = product exceeded 32 bits
saddress  input  16  bus address
srd  input  1  read strobe, one clk cycle, synchronous
swr  input  1  write strobe, one clk cycle, synchronous
sdata_in  input  32  bus write data
sdata_out  output  32  bus read data, registered
irq  output  1  interrupt, level, high while IRQ_PEND
level  output  AW+1  current entry count, 0..DEPTH

Behaviour:
- Reset (async assert, sync release): pointers=0, level=0, sdata_out=0, irq=0, drop counter=0, underflow sticky=0, irq FSM=IRQ_IDLE. FIFO storage is not cleared.
- Entry = {ovf, ones[5:0], w[31:0]}. Push on res_done. Written entry is readable the cycle after the push.
- Register map (offsets from BASE):
  - +0x00 HEAD_W, R: head W; 0 if empty. Peek only, no pop.
  - +0x08 HEAD_META, R: {25'b0, ovf, ones}; 0 if empty.
  - +0x10 POP, W: any data pops the head.
  - +0x18 STATUS, R: [0] empty, [1] full, [2] underflow sticky, [3] irq, [15:8] level zero-extended, [31:16] drop count.
  - +0x18 CTRL, W: bit0 flush, bit1 clear drops+underflow, bit2 irq ack.
  - Other addresses: reads return 0, writes are ignored.
- Read latency: sdata_out is updated on the clk edge where srd=1 and holds until the next srd. Value reflects state before any same-cycle push or pop.
- Push when full: entry discarded, drop counter +1, saturating at 16'hFFFF.
- POP when empty: no pointer change, underflow sticky set.
- Push and pop in the same cycle:
  - Not empty: both occur, level unchanged.
  - Full: pop then push, no drop.
  - Empty: push only, underflow set.
- Flush: pointers and level go to 0 next cycle. A same-cycle push is discarded and not counted as a drop. Drop counter is unaffected unless bit1 is also set.
- Pointers wrap modulo DEPTH. Level is computed from AW+1-bit pointers, so full and empty are distinguished.
- irq FSM, evaluated each cycle on the post-update level:
  - IRQ_IDLE -> IRQ_PEND when level >= THRESH.
  - IRQ_PEND -> IRQ_ACKED on ack write.
  - IRQ_ACKED -> IRQ_IDLE when level < THRESH.
  - Ack in IRQ_IDLE is ignored. Flush from any state goes to IRQ_IDLE.
  - irq = (state == IRQ_PEND).
- Reset mid-operation: immediate return to reset values. An in-flight res_done is lost.

Optional Feature:
RESFIFO_TIMESTAMP_EN
- Defined: adds a free-running 16-bit cycle counter (reset 0, wraps at 16'hFFFF). Each entry also stores the counter value at push time, readable at +0x20 HEAD_TS as {16'b0, ts}; 0 if empty.
- Undefined: no counter or storage; +0x20 reads 0.

Test Plan:
1. Reset, then read STATUS -> 32'h00000001 (empty). irq=0, level=0.
2. Push W=32'h0000_0C00, ones=2, ovf=0. Read HEAD_W -> 32'h00000C00. Read HEAD_META -> 32'h00000002. Write POP, then read STATUS -> empty=1.
3. Push 10 entries with W=1..10 into DEPTH=8 -> STATUS full=1, level=8, drops=2. Popping all returns W=1..8 in order.
4. Push 6 entries -> irq=1 the cycle after the 6th push. Ack -> irq=0. Pop 1 (level 5), push 1 (level 6) -> irq=1 again.
5. With level=3, same-cycle res_done and POP -> level stays 3. With level=0, POP -> STATUS[2]=1. CTRL write 2 -> STATUS[2]=0, drops=0.
6. With level=5, flush while res_done is high -> level=0, drops unchanged, irq=0. Assert n_reset mid-push -> all outputs return to reset values.
